// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and latched branch target for the
// multicycle accumulator CPU. Also resolves conditional branches and counts fetches.
module fetch_pc_unit #(
    parameter int              WIDTH    = 16,
    parameter int              OPW      = 5,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              CNTW     = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [1:0]           PCSrc,
    input  logic [1:0]           PCWrite,
    input  logic [1:0]           Branch,
    input  logic [1:0]           BneOrBeq,
    input  logic                 IRWrite,
    input  logic                 Zero,
    input  logic [WIDTH-1:0]     ALUResult,
    input  logic [WIDTH-1:0]     ACC,
    input  logic [WIDTH-1:0]     InstrIn,
    output logic [WIDTH-1:0]     PC,
    output logic [WIDTH-1:0]     Instr,
    output logic [OPW-1:0]       Opcode,
    output logic [WIDTH-OPW-1:0] Imm,
    output logic [WIDTH-1:0]     ImmSE,
    output logic [WIDTH-1:0]     BranchTarget,
    output logic                 BranchTaken,
    output logic [CNTW-1:0]      InstrCount
);

    localparam int IMMW = WIDTH - OPW;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] target_q;
    logic             decode_q;
    logic [CNTW-1:0]  count_q;

    logic             pc_write_en;
    logic             branch_cond;
    logic [WIDTH-1:0] jump_pc;
    logic [WIDTH-1:0] pc_sel;
    logic [WIDTH-1:0] pc_next;

    assign Opcode = ir_q[WIDTH-1:IMMW];
    assign Imm    = ir_q[IMMW-1:0];
    assign ImmSE  = {{OPW{ir_q[IMMW-1]}}, ir_q[IMMW-1:0]};

    // Region jump keeps the upper PC bits and replaces the rest with Imm word-aligned.
    assign jump_pc = {pc_q[WIDTH-1:IMMW+1], ir_q[IMMW-1:0], 1'b0};

    assign pc_write_en = (PCWrite != 2'b00);
    assign branch_cond = BneOrBeq[0] ? Zero : ~Zero;
    assign BranchTaken = (Branch != 2'b00) && !pc_write_en && branch_cond;

    always_comb begin
        pc_sel = pc_q;
        if (pc_write_en) begin
            case (PCSrc)
                2'd0:    pc_sel = ALUResult;
                2'd1:    pc_sel = jump_pc;
                2'd2:    pc_sel = target_q;
                default: pc_sel = ACC;
            endcase
        end else if (BranchTaken) begin
            pc_sel = target_q;
        end
    end

    // Instructions are halfword aligned; an odd source is silently aligned.
    assign pc_next = {pc_sel[WIDTH-1:1], 1'b0};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q     <= {RESET_PC[WIDTH-1:1], 1'b0};
            ir_q     <= '0;
            target_q <= '0;
            decode_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_next;
            decode_q <= IRWrite;
            if (IRWrite) begin
                ir_q    <= InstrIn;
                count_q <= count_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
            // The cycle after Fetch is Decode, when the ALU computes PC+ImmSE.
            if (decode_q) begin
                target_q <= ALUResult;
            end
        end
    end

    assign PC           = pc_q;
    assign Instr        = ir_q;
    assign BranchTarget = target_q;
    assign InstrCount   = count_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Holds the program counter (PC), the instruction register (IR) and the latched branch target for the multicycle accumulator CPU.
- Sits between instruction memory and the control FSM.
  - Upstream: it produces the Opcode the control FSM decodes.
  - Downstream: it consumes the FSM's PCSrc/PCWrite/Branch/BneOrBeq/IRWrite strobes.
- Also resolves conditional branches and counts fetched instructions.

Parameters:
- WIDTH, 16, datapath/address width; instructions are one WIDTH-bit word, byte-addressed, PC steps by 2.
- OPW, 5, opcode width, taken from IR[WIDTH-1:WIDTH-OPW].
- RESET_PC, 16'h0000, PC value after reset.
- CNTW, 32, width of the fetched-instruction counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCSrc  in  2  next-PC select when PCWrite is active.
- PCWrite  in  2  unconditional PC write; any nonzero value enables it.
- Branch  in  2  conditional PC write; any nonzero value enables it.
- BneOrBeq  in  2  bit0=1 selects beq (taken on Zero); bit0=0 selects bne (taken on !Zero).
- IRWrite  in  1  load IR from InstrIn.
- Zero  in  1  ALU zero flag, same cycle as Branch.
- ALUResult  in  WIDTH  combinational ALU output.
- ACC  in  WIDTH  accumulator value (register-indirect jump source).
- InstrIn  in  WIDTH  instruction memory read data at address PC.
- PC  out  WIDTH  current program counter.
- Instr  out  WIDTH  IR contents.
- Opcode  out  OPW  IR[15:11].
- Imm  out  WIDTH-OPW  IR[10:0].
- ImmSE  out  WIDTH  sign-extended Imm.
- BranchTarget  out  WIDTH  latched branch target register.
- BranchTaken  out  1  combinational; high when Branch!=0, PCWrite==0 and the condition holds.
- InstrCount  out  CNTW  number of IR loads since reset.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction) sets:
  - PC=RESET_PC; IR=0, so Opcode=0 and the FSM treats it as an illegal opcode and refetches; BranchTarget=0.
  - decode_q=0; InstrCount=0.
- IR: on an edge with IRWrite=1, IR<=InstrIn. Otherwise IR holds.
  - Opcode, Imm and ImmSE are purely combinational from IR; zero latency after the load edge.
- decode_q (internal flag) <= IRWrite each edge. It marks the Decode cycle, which immediately follows Fetch.
- BranchTarget: on an edge with decode_q=1, BranchTarget<=ALUResult. During Decode the FSM drives the ALU to PC+ImmSE. Otherwise BranchTarget holds.
- PC update priority, evaluated each edge:
  1. PCWrite!=0:
     - PCSrc=0: PC<=ALUResult.
     - PCSrc=1: PC<={PC[15:12], Imm, 1'b0} (jump/jal region form).
     - PCSrc=2: PC<=BranchTarget.
     - PCSrc=3: PC<=ACC.
  2. Else if BranchTaken: PC<=BranchTarget, regardless of PCSrc.
  3. Else PC holds.
- PC[0] is always forced to 0 on write. An odd ALUResult/ACC is silently aligned.
- PC arithmetic wraps modulo 2^WIDTH: 16'hFFFE+2 gives 16'h0000. No overflow flag.
- Simultaneous events:
  - IRWrite and PCWrite in the same edge (Fetch): IR captures InstrIn addressed by the OLD PC, and PC advances.
  - PCWrite and Branch both nonzero: PCWrite wins, and BranchTaken is 0.
  - decode_q and a PC write in the same edge: both take effect; BranchTarget gets the Decode-cycle ALUResult.
- InstrCount increments on every IRWrite edge. It wraps at 2^CNTW without saturating.
- No X propagation: every register has a defined reset value, and unused PCSrc encodings are fully decoded.

Test Plan:
- Reset then fetch: Reset pulse with InstrIn=16'h0805 (opcode 1, imm 5); one Fetch cycle with PCWrite=1, PCSrc=0, IRWrite=1, ALUResult=16'h0002 -> PC=0002, Opcode=5'b00001, Imm=11'd5, InstrCount=1.
- Decode latch plus beq taken: after Fetch, ALUResult=16'h0040 during the Decode cycle -> BranchTarget=0040; next cycle Branch=1, BneOrBeq=1, Zero=1 -> BranchTaken=1, PC=0040. Repeat with Zero=0 -> PC unchanged.
- bne with negative offset: IR=16'h27FE (opcode 4, imm -2) -> ImmSE=16'hFFFE; Decode ALUResult=16'h0010; Branch=1, BneOrBeq=0, Zero=0 -> PC=0010.
- Jump forms:
  - PC=16'h3004, IR imm=11'h123, PCWrite=1, PCSrc=1 -> PC=16'h3246.
  - PCSrc=3 with ACC=16'h1235 -> PC=16'h1234, bit0 forced low.
- Conflicts and wrap:
  - PCWrite=1, PCSrc=0, ALUResult=16'h0100 together with Branch=1, Zero=1 -> PC=0100, BranchTaken=0.
  - ALUResult=16'h0000 after PC=FFFE -> PC=0000.
- Asynchronous reset mid-instruction: assert Reset between clock edges during a Branch cycle -> PC, IR, BranchTarget and InstrCount go to 0 immediately, with no clock needed; the first post-reset edge with IRWrite=1 gives InstrCount=1.
